// File: rtl/svo_tmds_lanes.sv
// svo_tmds_lanes: N-lane TMDS encoder (DVI video, control, HDMI guard bands, TERC4 islands)
// with an output delay pipeline and a sticky period-sequence checker.
module svo_tmds_lanes #(
  parameter int NUM_LANES   = 3,
  parameter int ENABLE_HDMI = 1,
  parameter int PIPE_STAGES = 2,
  parameter int GUARD_LEN   = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [2:0]              period,
  input  logic [8*NUM_LANES-1:0]  din,
  input  logic [2*NUM_LANES-1:0]  ctrl,
  input  logic [4*NUM_LANES-1:0]  terc4,
  output logic [10*NUM_LANES-1:0] dout,
  output logic                    seq_err,
  input  logic                    err_clr
);
  localparam logic [2:0] P_CTRL = 3'd0, P_VGB = 3'd1, P_VDATA = 3'd2, P_DIGB = 3'd3, P_DIDATA = 3'd4;
  localparam bit HDMI = ENABLE_HDMI != 0;
  localparam logic [2:0] GL = 3'(GUARD_LEN);
  localparam logic [9:0] GB_A = 10'b1011001100, GB_B = 10'b0100110011;
  localparam logic [9:0] CTRL_SYM [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC4_SYM [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  function automatic logic [7:0] prefix_xor(input logic [7:0] v);
    for (int i = 0; i < 8; i++) prefix_xor[i] = ^(v & (8'hff >> (7 - i)));
  endfunction

  logic [10*NUM_LANES-1:0] enc_d;
  logic [10*NUM_LANES-1:0] pipe_q [PIPE_STAGES];
  logic signed [4:0] disp_q [NUM_LANES];
  logic signed [4:0] disp_d [NUM_LANES];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [7:0] d;
    logic [3:0] n1d, n1q;
    logic xn, first, inv;
    logic [8:0] qm;
    logic signed [4:0] b, c, adj, nxt;
    logic [9:0] vid, gb, tsym, csym;
    assign d = din[8*k +: 8];
    assign n1d = 4'($countones(d));
    assign xn = n1d > 4'd4 || (n1d == 4'd4 && !d[0]);
    // an XNOR chain is the XOR prefix with every odd bit inverted
    assign qm = {~xn, prefix_xor(d) ^ (xn ? 8'haa : 8'h00)};
    assign n1q = 4'($countones(qm[7:0]));
    // b = ones - zeros; 5-bit wraparound is exact since the result lies in -8..8
    assign b = $signed({n1q, 1'b0}) - 5'sd8;
    assign c = disp_q[k];
    assign first = c == 5'sd0 || b == 5'sd0;
    assign inv = first ? ~qm[8] : c[4] == b[4];
    assign adj = first ? 5'sd0 : inv ? (qm[8] ? 5'sd2 : 5'sd0) : (qm[8] ? 5'sd0 : -5'sd2);
    assign nxt = c + (inv ? -b : b) + adj;
    assign vid = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    assign gb = (k % 3 == 1) ? GB_B : GB_A;
    assign tsym = TERC4_SYM[terc4[4*k +: 4]];
    assign csym = CTRL_SYM[ctrl[2*k +: 2]];
    assign enc_d[10*k +: 10] = period == P_VDATA ? vid : !HDMI ? csym : period == P_VGB ? gb :
                               period == P_DIGB ? (k == 0 ? tsym : GB_B) : period == P_DIDATA ? tsym : csym;
    assign disp_d[k] = period == P_VDATA ? nxt : 5'sd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < PIPE_STAGES; s++) pipe_q[s] <= {NUM_LANES{CTRL_SYM[0]}};
      for (int j = 0; j < NUM_LANES; j++) disp_q[j] <= 5'sd0;
    end else begin
      pipe_q[0] <= enc_d;
      for (int s = 1; s < PIPE_STAGES; s++) pipe_q[s] <= pipe_q[s-1];
      disp_q <= disp_d;
    end
  end

  assign dout = pipe_q[PIPE_STAGES-1];

  typedef enum logic [2:0] {S_IDLE, S_VGB, S_VIDEO, S_IGB_LEAD, S_ISLAND, S_IGB_TRAIL} state_t;
  state_t st_q, st_d, imp;
  logic [2:0] cnt_q, cnt_d;
  logic legal, guard, cont, seq_err_q;

  // imp is where an error resynchronises to: the state the current period implies
  always_comb begin
    imp = !HDMI ? (period == P_VDATA ? S_VIDEO : S_IDLE) : period == P_VGB ? S_VGB :
          period == P_VDATA ? S_VIDEO : period == P_DIGB ? S_IGB_LEAD : period == P_DIDATA ? S_ISLAND : S_IDLE;
    guard = HDMI && (period == P_VGB || period == P_DIGB);
    cont = (st_q == S_VGB && period == P_VGB) || ((st_q == S_IGB_LEAD || st_q == S_IGB_TRAIL) && period == P_DIGB);
    legal = 1'b0;
    if (!HDMI) legal = period == P_CTRL || period == P_VDATA;
    else
      case (period)
        P_CTRL:   legal = st_q == S_IDLE || st_q == S_VIDEO || (st_q == S_IGB_TRAIL && cnt_q == GL);
        P_VGB:    legal = st_q == S_IDLE || (st_q == S_VGB && cnt_q < GL);
        P_VDATA:  legal = st_q == S_VIDEO || (st_q == S_VGB && cnt_q == GL);
        P_DIGB:   legal = st_q inside {S_IDLE, S_IGB_LEAD, S_ISLAND} || (st_q == S_IGB_TRAIL && cnt_q < GL);
        P_DIDATA: legal = st_q == S_ISLAND || (st_q == S_IGB_LEAD && cnt_q == GL);
        default:  legal = 1'b0;
      endcase
    st_d = legal && period == P_DIGB && (st_q == S_ISLAND || st_q == S_IGB_TRAIL) ? S_IGB_TRAIL : imp;
    cnt_d = !guard ? 3'd0 : !(legal && cont) ? 3'd1 : cnt_q == 3'd7 ? 3'd7 : cnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q <= S_IDLE;
      cnt_q <= 3'd0;
      seq_err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      seq_err_q <= !legal || (seq_err_q && !err_clr);
    end
  end

  assign seq_err = seq_err_q;
endmodule

// File: tb/tb_svo_tmds_lanes.sv
// tb_svo_tmds_lanes: randomized scoreboard bench for svo_tmds_lanes against a behavioural
// DVI/TERC4/guard-band encoder and period-rule model.
module tb_svo_tmds_lanes;
  localparam int NL = 3, PS = 2, GL = 2;
  localparam int DW = 8*NL, CW = 2*NL, TW = 4*NL;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] CTRL_S [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  logic clk = 0, resetn = 1, err_clr = 0;
  logic [2:0] period = 0;
  logic [DW-1:0] din = 0;
  logic [CW-1:0] ctrl = 0;
  logic [TW-1:0] terc4 = 0;
  logic [10*NL-1:0] dout;
  logic seq_err;

  svo_tmds_lanes #(.NUM_LANES(NL), .ENABLE_HDMI(1), .PIPE_STAGES(PS), .GUARD_LEN(GL)) dut (
    .clk(clk), .resetn(resetn), .period(period), .din(din), .ctrl(ctrl), .terc4(terc4),
    .dout(dout), .seq_err(seq_err), .err_clr(err_clr));

  always #5 clk = ~clk;

  typedef struct { int t; logic [10*NL-1:0] exp; bit lit; logic [9:0] lit0; } dq_t;
  typedef struct { int t; bit exp; bit lit; bit litv; } eq_t;
  dq_t dq[$];
  eq_t eq[$];
  int ecount = 0, n_cmp = 0, n_bad = 0;
  int disp [NL];
  int pp = 0, run = 0;
  bit trail = 0, err_m = 0;

  always @(posedge clk) ecount++;

  function automatic logic [9:0] video(input int k, input logic [7:0] d);
    int n1, b;
    bit x;
    logic [8:0] q;
    logic [9:0] s;
    n1 = $countones(d);
    x = n1 > 4 || (n1 == 4 && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
    q[8] = !x;
    b = 2*$countones(q[7:0]) - 8;
    if (disp[k] == 0 || b == 0) begin
      s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      disp[k] += q[8] ? b : -b;
    end else if ((disp[k] > 0) == (b > 0)) begin
      s = {1'b1, q[8], ~q[7:0]};
      disp[k] += 2*int'(q[8]) - b;
    end else begin
      s = {1'b0, q[8], q[7:0]};
      disp[k] += b - 2*int'(!q[8]);
    end
    return s;
  endfunction

  function automatic bit rule_ok(input int p);
    case (p)
      0: return pp == 0 || pp == 2 || (pp == 3 && trail && run == GL);
      1: return pp == 0 || (pp == 1 && run < GL);
      2: return pp == 2 || (pp == 1 && run == GL);
      3: return pp == 0 || pp == 4 || (pp == 3 && (!trail || run < GL));
      4: return pp == 4 || (pp == 3 && !trail && run == GL);
      default: return 0;
    endcase
  endfunction

  task automatic issue(input logic [2:0] p, input bit clr = 0, input bit lit = 0,
                       input logic [9:0] l0 = 0, input bit elit = 0, input bit ev = 0);
    logic [10*NL-1:0] e;
    logic [9:0] s;
    bit ok;
    int pi;
    period = p;
    err_clr = clr;
    pi = int'(p);
    for (int k = 0; k < NL; k++) begin
      case (pi)
        1: s = (k % 3 == 1) ? 10'b0100110011 : 10'b1011001100;
        2: s = video(k, din[8*k +: 8]);
        3: s = k == 0 ? TERC[terc4[3:0]] : 10'b0100110011;
        4: s = TERC[terc4[4*k +: 4]];
        default: s = CTRL_S[ctrl[2*k +: 2]];
      endcase
      if (pi != 2) disp[k] = 0;
      e[10*k +: 10] = s;
    end
    ok = rule_ok(pi);
    if (ok) begin
      trail = pi == 3 && (pp == 4 || (pp == 3 && trail));
      run = (pi == pp && (pi == 1 || pi == 3)) ? (run < 7 ? run + 1 : 7) : 1;
    end else begin
      trail = 0;
      run = 1;
    end
    pp = pi > 4 ? 0 : pi;
    err_m = !ok || (err_m && !clr);
    dq.push_back('{ecount, e, lit, l0});
    eq.push_back('{ecount, err_m, elit, ev});
    @(negedge clk);
  endtask

  task automatic rnd_inputs();
    din = DW'($urandom);
    ctrl = CW'($urandom);
    terc4 = TW'($urandom);
  endtask

  task automatic do_reset();
    #2 resetn = 0;
    dq.delete();
    eq.delete();
    #1;
    n_cmp++;
    if (dout !== {NL{C00}}) begin n_bad++; $display("FAIL reset_dout got %h want %h", dout, {NL{C00}}); end
    n_cmp++;
    if (seq_err !== 1'b0) begin n_bad++; $display("FAIL reset_seq_err got %b want 0", seq_err); end
    for (int k = 0; k < NL; k++) disp[k] = 0;
    pp = 0; run = 0; trail = 0; err_m = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    dq_t d;
    eq_t q;
    forever begin
      @(posedge clk);
      #1;
      while (dq.size() > 0 && dq[0].t + PS <= ecount) begin
        d = dq.pop_front();
        n_cmp++;
        if (dout !== d.exp) begin n_bad++; $display("FAIL dout@%0d got %h want %h", d.t, dout, d.exp); end
        if (d.lit) begin
          n_cmp++;
          if (dout[9:0] !== d.lit0) begin n_bad++; $display("FAIL lane0_sym@%0d got %b want %b", d.t, dout[9:0], d.lit0); end
        end
      end
      while (eq.size() > 0 && eq[0].t + 1 <= ecount) begin
        q = eq.pop_front();
        n_cmp++;
        if (seq_err !== q.exp) begin n_bad++; $display("FAIL seq_err@%0d got %b want %b", q.t, seq_err, q.exp); end
        if (q.lit) begin
          n_cmp++;
          if (seq_err !== q.litv) begin n_bad++; $display("FAIL seq_err_dir@%0d got %b want %b", q.t, seq_err, q.litv); end
        end
      end
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    @(negedge clk);
    do_reset();
    ctrl = 0; din = 0; terc4 = 0;
    repeat (4) issue(0, 0, 1, C00, 1, 0);
    ctrl = CW'(3);
    issue(0, 0, 1, 10'b1010101011);
    ctrl = 0;
    repeat (2) issue(1, 0, 1, 10'b1011001100);
    din = 0;
    issue(2, 0, 1, 10'b0100000000);
    repeat (5) issue(2);
    issue(0, 0, 0, 0, 1, 0);
    terc4 = TW'(12'h55C);
    repeat (2) issue(3, 0, 1, 10'b1010001110);
    terc4[3:0] = 4'h0; issue(4, 0, 1, 10'b1010011100);
    terc4[3:0] = 4'h5; issue(4, 0, 1, 10'b0100011110);
    terc4[3:0] = 4'hF; issue(4, 0, 1, 10'b1011000011);
    terc4[3:0] = 4'hC;
    repeat (2) issue(3, 0, 1, 10'b1010001110);
    issue(0, 0, 0, 0, 1, 0);
    issue(1);
    issue(2, 0, 0, 0, 1, 1);
    issue(2, 0, 0, 0, 1, 1);
    issue(0, 0, 0, 0, 1, 1);
    issue(0, 1, 0, 0, 1, 0);
    issue(1, 0, 0, 0, 1, 0);
    issue(0, 1, 0, 0, 1, 1);
    issue(0, 1, 0, 0, 1, 0);
    repeat (GL) issue(1);
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        do_reset();
        issue(0);
        repeat (GL) issue(1);
      end
      din = DW'($urandom);
      issue(2);
    end
    issue(0);
    for (int b = 0; b < 300; b++) begin
      case ($urandom_range(0, 3))
        0: begin
          repeat (GL) begin rnd_inputs(); issue(1); end
          n = $urandom_range(1, 20);
          repeat (n) begin rnd_inputs(); issue(2); end
          n = $urandom_range(1, 4);
          repeat (n) begin rnd_inputs(); issue(0); end
        end
        1: begin
          repeat (GL) begin rnd_inputs(); issue(3); end
          n = $urandom_range(1, 10);
          repeat (n) begin rnd_inputs(); issue(4); end
          repeat (GL) begin rnd_inputs(); issue(3); end
          n = $urandom_range(1, 3);
          repeat (n) begin rnd_inputs(); issue(0); end
        end
        2: begin
          n = $urandom_range(1, 6);
          repeat (n) begin rnd_inputs(); issue(3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0); end
        end
        default: begin
          n = $urandom_range(1, 4);
          repeat (n) begin rnd_inputs(); issue(0, $urandom_range(0, 3) == 0); end
        end
      endcase
    end
    repeat (PS + 2) @(negedge clk);
    n_cmp++;
    if (dq.size() != 0 || eq.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending dout=%0d err=%0d want 0", dq.size(), eq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
